decode_cycle: RTL and testbench
===============================

Name: decode_cycle

Overview:
- Second stage of the 5-stage RV32I pipeline; consumes instr_f, pc_f, pc_plus4_f from the fetch stage.
- Holds the IF/ID pipeline register, 32x32 register file, main/ALU control decoder and immediate extender, and the ID/EX pipeline register feeding the execute stage.
- Accepts writeback from the W stage.
- Exposes rs1_d/rs2_d and registered rs1_e/rs2_e/rd_e to the hazard unit.

Parameters:
- XLEN, 32, datapath width
- NREGS, 32, architectural register count (x0 hardwired to 0)

Ports:
- clk  in  1  clock, all state updates on rising edge
- srst  in  1  synchronous reset, active-high
- stall_d  in  1  hold IF/ID register
- flush_d  in  1  clear IF/ID register (taken branch/jump)
- flush_e  in  1  clear ID/EX register (load-use bubble, taken branch)
- instr_f  in  32  fetched instruction
- pc_f  in  32  fetch PC
- pc_plus4_f  in  32  fetch PC+4
- regwrite_w  in  1  writeback enable
- rd_w  in  5  writeback destination
- result_w  in  32  writeback data
- rs1_d, rs2_d  out  5  source fields of the instruction in D (to hazard unit)
- regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e  out  1 each  registered controls
- resultsrc_e  out  2  00 ALU, 01 memory, 10 PC+4
- alucontrol_e  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- rd1_e, rd2_e, immext_e, pc_e, pc_plus4_e  out  32 each
- rs1_e, rs2_e, rd_e  out  5 each

Behaviour:
- Reset: srst clears IF/ID (instr_d, pc_d, pc_plus4_d = 0), all ID/EX outputs = 0, and all 32 registers = 0. Reset mid-operation discards in-flight instructions.
- IF/ID priority: srst > flush_d > stall_d > load.
  - flush_d clears the register to 0.
  - stall_d holds the current value.
  - flush_d with stall_d: flush wins.
- ID/EX priority: srst > flush_e > load. No stall. Cleared state means all controls 0 (bubble).
- Latency: instr_f sampled at edge N is decoded in cycle N+1 and appears on *_e after edge N+1.
- Register file:
  - 2 combinational read ports, 1 write port.
  - Write on the rising edge when regwrite_w and rd_w != 0; x0 reads 0 always.
  - Same-cycle bypass: if regwrite_w and rd_w == rs and rd_w != 0, the read returns result_w.
- Decoder, by opcode:
  - 0000011 lw: regwrite, alusrc, resultsrc 01, imm I.
  - 0100011 sw: memwrite, alusrc, imm S.
  - 0110011 R-type: regwrite, aluop 10.
  - 0010011 I-ALU: regwrite, alusrc, aluop 10, imm I.
  - 1100011 beq: branch, aluop 01, imm B.
  - 1101111 jal: regwrite, jump, resultsrc 10, imm J.
  - Any other opcode, including 0: all controls 0.
- ALU decode:
  - aluop 00 -> add.
  - aluop 01 -> sub.
  - aluop 10 by funct3:
    - 000: sub if R-type and funct7[5]=1, else add.
    - 010: slt. 110: or. 111: and.
    - Others: add.
- Immediate, sign-extended from instr[31]:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Field extraction: rd = instr[11:7], rs1 = instr[19:15], rs2 = instr[24:20], passed through unchanged for every opcode.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants
  - immsrc_t enum (I, S, B, J)
  - alucontrol encodings
  - resultsrc encodings
  - ctrl_t struct bundling the D-stage control signals
- One natural sub-module: reg_file (2R1W with bypass and x0 handling).
- Decoder and extender stay as always_comb blocks in decode_cycle.

Test Plan:
- Reset then instr_f=0x00500093 (addi x1,x0,5) -> next cycle: regwrite_e=1, alusrc_e=1, immext_e=5, rd_e=1, alucontrol_e=000.
- Writeback regwrite_w=1, rd_w=3, result_w=0xDEADBEEF while D holds add x4,x3,x3 (0x00318233) -> rd1_e=rd2_e=0xDEADBEEF via bypass. Repeat with rd_w=0 -> x0 stays 0.
- stall_d=1 for 2 cycles with changing instr_f -> instr in D and rs1_d unchanged. Then flush_d=1 with stall_d=1 -> IF/ID cleared, next *_e controls all 0.
- flush_e=1 with valid lw x5,-4(x2) (0xFFC12283) in D -> *_e all 0. Same instr without flush -> resultsrc_e=01, immext_e=0xFFFFFFFC.
- beq with imm=-8 (0xFE208CE3) -> branch_e=1, alucontrol_e=001, immext_e=0xFFFFFFF8. jal x1,+2048 (0x001000EF) -> jump_e=1, resultsrc_e=10, immext_e=0x00000800.
- srst asserted mid-stream with regs loaded -> all outputs 0 next cycle and a later read of x3 returns 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate selects, ALU/result encodings
// and the bundled decode-stage control word.
package riscv_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} immsrc_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       regwrite;
      logic       memwrite;
      logic       jump;
      logic       branch;
      logic       alusrc;
      logic [1:0] resultsrc;
      logic [1:0] aluop;
      immsrc_t    immsrc;
   } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 2-read / 1-write register file; x0 reads zero and a same-cycle write is
// bypassed to the read ports so decode never sees stale writeback data.
module reg_file #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic [$clog2(NREGS)-1:0] a1,
   input  logic [$clog2(NREGS)-1:0] a2,
   output logic [XLEN-1:0]          rd1,
   output logic [XLEN-1:0]          rd2,
   input  logic                     we,
   input  logic [$clog2(NREGS)-1:0] wa,
   input  logic [XLEN-1:0]          wd
);

   logic [XLEN-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (srst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && wa != '0) begin
         regs[wa] <= wd;
      end
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (a1 != '0) rd1 = (we && wa == a1) ? wd : regs[a1];
      if (a2 != '0) rd2 = (we && wa == a2) ? wd : regs[a2];
   end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: IF/ID register, register file, control/ALU decode,
// immediate extension and the ID/EX register handed to execute.
module decode_cycle
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            srst,
   input  logic            stall_d,
   input  logic            flush_d,
   input  logic            flush_e,
   input  logic [31:0]     instr_f,
   input  logic [XLEN-1:0] pc_f,
   input  logic [XLEN-1:0] pc_plus4_f,
   input  logic            regwrite_w,
   input  logic [4:0]      rd_w,
   input  logic [XLEN-1:0] result_w,
   output logic [4:0]      rs1_d,
   output logic [4:0]      rs2_d,
   output logic            regwrite_e,
   output logic            memwrite_e,
   output logic            jump_e,
   output logic            branch_e,
   output logic            alusrc_e,
   output logic [1:0]      resultsrc_e,
   output logic [2:0]      alucontrol_e,
   output logic [XLEN-1:0] rd1_e,
   output logic [XLEN-1:0] rd2_e,
   output logic [XLEN-1:0] immext_e,
   output logic [XLEN-1:0] pc_e,
   output logic [XLEN-1:0] pc_plus4_e,
   output logic [4:0]      rs1_e,
   output logic [4:0]      rs2_e,
   output logic [4:0]      rd_e
);

   logic [31:0]     instr_d;
   logic [XLEN-1:0] pc_d, pc_plus4_d;
   logic [XLEN-1:0] rd1_d, rd2_d, immext_d;
   logic [2:0]      alucontrol_d;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   ctrl_t           ctrl;

   // flush beats stall so a taken branch always kills the wrong-path instruction
   always_ff @(posedge clk) begin
      if (srst || flush_d) begin
         instr_d    <= '0;
         pc_d       <= '0;
         pc_plus4_d <= '0;
      end else if (!stall_d) begin
         instr_d    <= instr_f;
         pc_d       <= pc_f;
         pc_plus4_d <= pc_plus4_f;
      end
   end

   assign opcode = instr_d[6:0];
   assign funct3 = instr_d[14:12];
   assign rs1_d  = instr_d[19:15];
   assign rs2_d  = instr_d[24:20];

   reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
      .clk  (clk),
      .srst (srst),
      .a1   (rs1_d),
      .a2   (rs2_d),
      .rd1  (rd1_d),
      .rd2  (rd2_d),
      .we   (regwrite_w),
      .wa   (rd_w),
      .wd   (result_w)
   );

   always_comb begin
      ctrl = '0;
      case (opcode)
         OP_LW:  begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.resultsrc = RES_MEM; end
         OP_SW:  begin ctrl.memwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.immsrc = IMM_S; end
         OP_R:   begin ctrl.regwrite = 1'b1; ctrl.aluop = ALUOP_FUNCT; end
         OP_I:   begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.aluop = ALUOP_FUNCT; end
         OP_BEQ: begin ctrl.branch = 1'b1; ctrl.aluop = ALUOP_SUB; ctrl.immsrc = IMM_B; end
         OP_JAL: begin
            ctrl.regwrite  = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.resultsrc = RES_PC4;
            ctrl.immsrc    = IMM_J;
         end
         default: ctrl = '0;
      endcase
   end

   always_comb begin
      alucontrol_d = ALU_ADD;
      case (ctrl.aluop)
         ALUOP_SUB:   alucontrol_d = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // only register-register ops use funct7[5]; addi with a negative imm must stay add
               3'b000:  alucontrol_d = (opcode == OP_R && instr_d[30]) ? ALU_SUB : ALU_ADD;
               3'b010:  alucontrol_d = ALU_SLT;
               3'b110:  alucontrol_d = ALU_OR;
               3'b111:  alucontrol_d = ALU_AND;
               default: alucontrol_d = ALU_ADD;
            endcase
         end
         default: alucontrol_d = ALU_ADD;
      endcase
   end

   always_comb begin
      immext_d = '0;
      case (ctrl.immsrc)
         IMM_I: immext_d = {{(XLEN-12){instr_d[31]}}, instr_d[31:20]};
         IMM_S: immext_d = {{(XLEN-12){instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
         IMM_B: immext_d = {{(XLEN-12){instr_d[31]}}, instr_d[7], instr_d[30:25],
                            instr_d[11:8], 1'b0};
         IMM_J: immext_d = {{(XLEN-20){instr_d[31]}}, instr_d[19:12], instr_d[20],
                            instr_d[30:21], 1'b0};
         default: immext_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst || flush_e) begin
         regwrite_e   <= 1'b0;
         memwrite_e   <= 1'b0;
         jump_e       <= 1'b0;
         branch_e     <= 1'b0;
         alusrc_e     <= 1'b0;
         resultsrc_e  <= '0;
         alucontrol_e <= '0;
         rd1_e        <= '0;
         rd2_e        <= '0;
         immext_e     <= '0;
         pc_e         <= '0;
         pc_plus4_e   <= '0;
         rs1_e        <= '0;
         rs2_e        <= '0;
         rd_e         <= '0;
      end else begin
         regwrite_e   <= ctrl.regwrite;
         memwrite_e   <= ctrl.memwrite;
         jump_e       <= ctrl.jump;
         branch_e     <= ctrl.branch;
         alusrc_e     <= ctrl.alusrc;
         resultsrc_e  <= ctrl.resultsrc;
         alucontrol_e <= alucontrol_d;
         rd1_e        <= rd1_d;
         rd2_e        <= rd2_d;
         immext_e     <= immext_d;
         pc_e         <= pc_d;
         pc_plus4_e   <= pc_plus4_d;
         rs1_e        <= rs1_d;
         rs2_e        <= rs2_d;
         rd_e         <= instr_d[11:7];
      end
   end

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed scenarios plus randomized traffic
// against an instruction-level model of the decode stage.
module tb_decode_cycle;

   logic        clk = 1'b0;
   logic        srst, stall_d, flush_d, flush_e, regwrite_w;
   logic [31:0] instr_f, pc_f, pc_plus4_f, result_w;
   logic [4:0]  rd_w;
   wire  [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
   wire         regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e;
   wire  [1:0]  resultsrc_e;
   wire  [2:0]  alucontrol_e;
   wire  [31:0] rd1_e, rd2_e, immext_e, pc_e, pc_plus4_e;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decode_cycle dut (
      .clk(clk), .srst(srst), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .instr_f(instr_f), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f),
      .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
      .rs1_d(rs1_d), .rs2_d(rs2_d),
      .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .jump_e(jump_e),
      .branch_e(branch_e), .alusrc_e(alusrc_e), .resultsrc_e(resultsrc_e),
      .alucontrol_e(alucontrol_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .immext_e(immext_e),
      .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
   );

   wire [184:0] dut_e = {regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e, resultsrc_e,
                         alucontrol_e, rd1_e, rd2_e, immext_e, pc_e, pc_plus4_e,
                         rs1_e, rs2_e, rd_e};
   wire [9:0]   dut_ctrl = dut_e[184:175];

   // model state: what sits in decode, the architectural registers, and the expected E bundle
   logic [31:0]  m_instr, m_pc, m_pc4;
   logic [31:0]  m_regs [32];
   logic [184:0] m_e;

   function automatic logic [31:0] rreg(logic [4:0] r);
      return (r == 5'd0) ? 32'd0 : m_regs[r];
   endfunction

   // Expected execute bundle for an instruction, from the ISA description of each opcode
   function automatic logic [184:0] model_e(logic [31:0] i, logic [31:0] pc, logic [31:0] pc4);
      logic rw, mw, jmp, br, as;
      logic [1:0] res;
      logic [2:0] alu;
      int imm;
      logic [31:0] immv;
      rw = 0; mw = 0; jmp = 0; br = 0; as = 0; res = 2'b00; alu = 3'b000;
      imm = $signed(i[31:20]);
      case (i[6:0])
         7'h03: begin rw = 1; as = 1; res = 2'b01; end
         7'h23: begin mw = 1; as = 1; imm = $signed({i[31:25], i[11:7]}); end
         7'h33, 7'h13: begin
            rw = 1;
            as = (i[6:0] == 7'h13);
            if (i[14:12] == 3'b000 && i[6:0] == 7'h33 && i[30]) alu = 3'b001;
            else if (i[14:12] == 3'b010) alu = 3'b101;
            else if (i[14:12] == 3'b110) alu = 3'b011;
            else if (i[14:12] == 3'b111) alu = 3'b010;
         end
         7'h63: begin br = 1; alu = 3'b001; imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
         7'h6F: begin
            rw = 1; jmp = 1; res = 2'b10;
            imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
         end
         default: ;
      endcase
      immv = imm;
      return {rw, mw, jmp, br, as, res, alu, rreg(i[19:15]), rreg(i[24:20]), immv,
              pc, pc4, i[19:15], i[24:20], i[11:7]};
   endfunction

   // Advance the model by one clock using the inputs currently driven, then step the DUT
   task automatic tick();
      if (srst) begin
         for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
         m_e = '0;
         m_instr = 0; m_pc = 0; m_pc4 = 0;
      end else begin
         if (regwrite_w && rd_w != 5'd0) m_regs[rd_w] = result_w;
         m_e = flush_e ? '0 : model_e(m_instr, m_pc, m_pc4);
         if (flush_d) begin
            m_instr = 0; m_pc = 0; m_pc4 = 0;
         end else if (!stall_d) begin
            m_instr = instr_f; m_pc = pc_f; m_pc4 = pc_plus4_f;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      srst = 0; stall_d = 0; flush_d = 0; flush_e = 0; regwrite_w = 0;
      rd_w = 0; result_w = 0; instr_f = 0;
      pc_f = $urandom(); pc_plus4_f = pc_f + 32'd4;
   endtask

   task automatic test_reset();
      drive_idle();
      srst = 1;
      tick();
      tick();
      checks++;
      if (dut_e !== 185'd0) begin
         failures++; $display("FAIL reset_e got=%h exp=0", dut_e);
      end
      checks++;
      if ({rs1_d, rs2_d} !== 10'd0) begin
         failures++; $display("FAIL reset_rs got=%h exp=0", {rs1_d, rs2_d});
      end
      srst = 0;
   endtask

   task automatic test_addi();
      drive_idle();
      instr_f = 32'h00500093;
      tick();
      instr_f = 32'h0;
      tick();
      checks++;
      if ({regwrite_e, alusrc_e, immext_e, rd_e, alucontrol_e} !== {1'b1, 1'b1, 32'd5, 5'd1, 3'b000}) begin
         failures++;
         $display("FAIL addi got rw=%b as=%b imm=%h rd=%0d alu=%b", regwrite_e, alusrc_e, immext_e, rd_e, alucontrol_e);
      end
      checks++;
      if (dut_e !== m_e) begin
         failures++; $display("FAIL addi_model got=%h exp=%h", dut_e, m_e);
      end
   endtask

   task automatic test_bypass();
      drive_idle();
      instr_f = 32'h00318233;
      tick();
      instr_f = 32'h0;
      regwrite_w = 1; rd_w = 5'd3; result_w = 32'hDEADBEEF;
      tick();
      checks++;
      if ({rd1_e, rd2_e} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
         failures++; $display("FAIL bypass got=%h %h exp=deadbeef", rd1_e, rd2_e);
      end
      // a write aimed at x0 must be dropped, including the bypass path
      drive_idle();
      instr_f = 32'h00000233;
      tick();
      regwrite_w = 1; rd_w = 5'd0; result_w = 32'h12345678;
      tick();
      checks++;
      if ({rd1_e, rd2_e} !== 64'd0) begin
         failures++; $display("FAIL x0_write got=%h %h exp=0", rd1_e, rd2_e);
      end
      checks++;
      if (dut_e !== m_e) begin
         failures++; $display("FAIL x0_model got=%h exp=%h", dut_e, m_e);
      end
   endtask

   task automatic test_stall_flush();
      drive_idle();
      instr_f = 32'h00318233;
      tick();
      stall_d = 1;
      for (int k = 0; k < 2; k++) begin
         instr_f = $urandom();
         tick();
         checks++;
         if ({rs1_d, rs2_d} !== {5'd3, 5'd3}) begin
            failures++; $display("FAIL stall_hold got=%0d %0d exp=3 3", rs1_d, rs2_d);
         end
      end
      checks++;
      if (dut_e !== m_e) begin
         failures++; $display("FAIL stall_model got=%h exp=%h", dut_e, m_e);
      end
      flush_d = 1;
      tick();
      checks++;
      if ({rs1_d, rs2_d} !== 10'd0) begin
         failures++; $display("FAIL flush_over_stall got=%h exp=0", {rs1_d, rs2_d});
      end
      flush_d = 0; stall_d = 0; instr_f = 32'h00500093;
      tick();
      checks++;
      if (dut_ctrl !== 10'd0) begin
         failures++; $display("FAIL flush_bubble got=%h exp=0", dut_ctrl);
      end
   endtask

   task automatic test_flush_e_lw();
      drive_idle();
      instr_f = 32'hFFC12283;
      tick();
      flush_e = 1; stall_d = 1;
      tick();
      checks++;
      if (dut_e !== 185'd0) begin
         failures++; $display("FAIL flush_e got=%h exp=0", dut_e);
      end
      flush_e = 0; stall_d = 0; instr_f = 32'h0;
      tick();
      checks++;
      if ({resultsrc_e, immext_e, rd_e, regwrite_e, alusrc_e} !== {2'b01, 32'hFFFFFFFC, 5'd5, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL lw got res=%b imm=%h rd=%0d rw=%b as=%b", resultsrc_e, immext_e, rd_e, regwrite_e, alusrc_e);
      end
   endtask

   task automatic test_branch_jal();
      drive_idle();
      instr_f = 32'hFE208CE3;
      tick();
      instr_f = 32'h001000EF;
      tick();
      checks++;
      if ({branch_e, alucontrol_e, immext_e, regwrite_e} !== {1'b1, 3'b001, 32'hFFFFFFF8, 1'b0}) begin
         failures++; $display("FAIL beq got br=%b alu=%b imm=%h", branch_e, alucontrol_e, immext_e);
      end
      instr_f = 32'h0;
      tick();
      checks++;
      if ({jump_e, resultsrc_e, immext_e, rd_e} !== {1'b1, 2'b10, 32'h00000800, 5'd1}) begin
         failures++; $display("FAIL jal got j=%b res=%b imm=%h rd=%0d", jump_e, resultsrc_e, immext_e, rd_e);
      end
      checks++;
      if (dut_e !== m_e) begin
         failures++; $display("FAIL jal_model got=%h exp=%h", dut_e, m_e);
      end
   endtask

   task automatic test_reset_mid();
      drive_idle();
      regwrite_w = 1; rd_w = 5'd3; result_w = 32'h13579BDF;
      instr_f = 32'h00318233;
      tick();
      regwrite_w = 0;
      tick();
      checks++;
      if (rd1_e !== 32'h13579BDF) begin
         failures++; $display("FAIL preload got=%h exp=13579bdf", rd1_e);
      end
      srst = 1;
      tick();
      checks++;
      if ({dut_e, rs1_d, rs2_d} !== 195'd0) begin
         failures++; $display("FAIL mid_reset got=%h exp=0", {dut_e, rs1_d, rs2_d});
      end
      srst = 0;
      tick();
      instr_f = 32'h0;
      tick();
      checks++;
      if ({rd1_e, rd2_e, rs1_e} !== {64'd0, 5'd3}) begin
         failures++; $display("FAIL x3_after_reset got=%h %h rs1=%0d exp=0 0 3", rd1_e, rd2_e, rs1_e);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [7];
      logic [31:0] r;
      ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13;
      ops[4] = 7'h63; ops[5] = 7'h6F; ops[6] = 7'h00;
      drive_idle();
      for (int n = 0; n < 400; n++) begin
         r = $urandom();
         r[6:0] = ($urandom_range(0, 7) == 7) ? 7'($urandom()) : ops[$urandom_range(0, 6)];
         instr_f    = r;
         pc_f       = $urandom();
         pc_plus4_f = pc_f + 32'd4;
         srst       = ($urandom_range(0, 59) == 0);
         stall_d    = ($urandom_range(0, 3) == 0);
         flush_d    = ($urandom_range(0, 7) == 0);
         flush_e    = ($urandom_range(0, 7) == 0);
         regwrite_w = $urandom_range(0, 1);
         rd_w       = 5'($urandom_range(0, 7));
         result_w   = $urandom();
         tick();
         checks++;
         if (dut_e !== m_e) begin
            failures++; $display("FAIL rand_e[%0d] got=%h exp=%h", n, dut_e, m_e);
         end
         checks++;
         if ({rs1_d, rs2_d} !== {m_instr[19:15], m_instr[24:20]}) begin
            failures++; $display("FAIL rand_rs[%0d] got=%h exp=%h", n, {rs1_d, rs2_d}, {m_instr[19:15], m_instr[24:20]});
         end
      end
      drive_idle();
   endtask

   initial begin
      m_instr = 0; m_pc = 0; m_pc4 = 0; m_e = '0;
      for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
      drive_idle();
      test_reset();
      test_addi();
      test_bypass();
      test_stall_flush();
      test_flush_e_lw();
      test_branch_jal();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
